rom_block_copier: RTL and testbench

- Bus initiator for the ROM read interface: drives ce/oce/ad toward an 8K pROM responder and samples the shared 8-bit data_bus.
- Copies a block of len bytes from ROM into a synchronous RAM write port, e.g. a boot-time copy of the ROM image or character set into DRAM/video RAM.
- Streams one read per cycle with a fixed read latency, tracked by an in-flight valid pipeline.
- Sits between the boot/control FSM (start/done) and the ROM plus RAM write port.

---
 rtl/rom_bus_pkg.sv | 16 +
 rtl/rd_valid_pipe.sv | 30 +++
 rtl/rom_block_copier.sv | 119 +++++++++++
 tb/tb_rom_block_copier.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_bus_pkg.sv
// Shared constants and state encoding for the ROM-to-RAM block copier.
package rom_bus_pkg;

  localparam int ROM_AW = 13;
  localparam int RAM_AW = 16;
  localparam int LEN_W  = 14;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } copier_state_e;

endpackage

// File: rtl/rd_valid_pipe.sv
// Shift register of ROM issue-valid bits; the tail marks the cycle whose data_bus byte is captured.
module rd_valid_pipe #(
  parameter int READ_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic issue,
  output logic vld_out,
  output logic any
);

  logic [READ_LAT-1:0] vld_p;

  // stage boundary: one bit per cycle of ROM read latency
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  assign vld_out = vld_p[READ_LAT-1];
  assign any     = |vld_p;

endmodule

// File: rtl/rom_block_copier.sv
// Streams len bytes from the pROM read port into a RAM write port, one read per cycle.
module rom_block_copier
  import rom_bus_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ROM_AW-1:0] src_addr,
  input  logic [RAM_AW-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic [ROM_AW-1:0] rom_ad,
  input  logic [DATA_W-1:0] data_bus,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done
);

  copier_state_e     state, state_nxt;
  logic [LEN_W-1:0]  remain;
  logic [RAM_AW-1:0] wr_ptr;
  logic              active, flush, issue, last_issue;
  logic              cap_vld, pipe_any, cap_en;

  assign active     = (state == FETCH) || (state == DRAIN);
  assign flush      = active && abort;
  assign issue      = (state == FETCH) && !abort;
  assign last_issue = (remain == LEN_W'(1));
  assign cap_en     = cap_vld && !flush;

  rd_valid_pipe #(
    .READ_LAT(READ_LAT)
  ) u_rd_valid_pipe (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .issue  (issue),
    .vld_out(cap_vld),
    .any    (pipe_any)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rom_ce    = 1'b0;
    busy      = active;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? DONE : FETCH;
      end
      FETCH: begin
        rom_ce = 1'b1;
        if (abort)           state_nxt = IDLE;
        else if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Enable stays up only while a byte is still on its way to capture.
        rom_ce = pipe_any;
        if (abort)          state_nxt = IDLE;
        else if (!pipe_any) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rom_oce = rom_ce;

  // stage boundary: ROM address issue
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_ad <= '0;
      remain <= '0;
    end else begin
      if (state == IDLE) begin
        if (start && (len != '0)) begin
          rom_ad <= src_addr;
          remain <= len;
        end
      end else if (state == FETCH && !last_issue) begin
        rom_ad <= rom_ad + ROM_AW'(1);
        remain <= remain - LEN_W'(1);
      end
    end
  end

  // stage boundary: data_bus capture into the RAM write port
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      wr_ptr    <= '0;
    end else begin
      ram_we <= cap_en;
      if (state == IDLE && start) wr_ptr <= dst_addr;
      if (cap_en) begin
        ram_addr  <= wr_ptr;
        ram_wdata <= data_bus;
        wr_ptr    <= wr_ptr + RAM_AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rom_block_copier.sv
// Directed bench: three copiers (READ_LAT 2, 1, 4) each paired with a pROM model whose content is ad[7:0]^A5.
module tb_rom_block_copier;

  localparam int NI = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [NI-1:0]   start, abort;
  logic [12:0]     src;
  logic [15:0]     dst;
  logic [13:0]     len;
  logic [NI-1:0]   rom_ce, rom_oce, ram_we, busy, done;
  logic [12:0]     rom_ad    [NI];
  logic [15:0]     ram_addr  [NI];
  logic [7:0]      ram_wdata [NI];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [12:0] hist [4];
    logic [7:0]  bus;

    rom_block_copier #(.READ_LAT(L)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start[g]),
      .abort    (abort[g]),
      .src_addr (src),
      .dst_addr (dst),
      .len      (len),
      .rom_ce   (rom_ce[g]),
      .rom_oce  (rom_oce[g]),
      .rom_ad   (rom_ad[g]),
      .data_bus (bus),
      .ram_we   (ram_we[g]),
      .ram_addr (ram_addr[g]),
      .ram_wdata(ram_wdata[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );

    // pROM responder: drives the byte for the address seen L cycles ago, only while ce && oce
    always @(posedge clk) begin
      hist[0] <= rom_ad[g];
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
    end
    assign bus = (rom_ce[g] && rom_oce[g]) ? (hist[L-1][7:0] ^ 8'hA5) : 8'hxx;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Start a copy in the current cycle (cycle 0) and score every write until done.
  task automatic run_copy(input int idx, input int lat, input int src_i, input int dst_i,
                          input int len_i, input int restart_at, input bit with_abort);
    int wr;
    int done_at;
    src = src_i[12:0];
    dst = dst_i[15:0];
    len = len_i[13:0];
    start[idx] = 1'b1;
    abort[idx] = with_abort;
    tick();
    start[idx] = 1'b0;
    abort[idx] = 1'b0;
    wr = 0;
    done_at = -1;
    for (int c = 1; c <= len_i + lat + 8 && done_at < 0; c++) begin
      if (c == restart_at) begin
        src = 13'h0AAA;
        len = 14'd20;
        start[idx] = 1'b1;
      end
      if (ram_we[idx]) begin
        chk("wr_addr", ram_addr[idx], (dst_i + wr) & 32'hFFFF);
        chk("wr_data", ram_wdata[idx], ((src_i + wr) & 32'hFF) ^ 32'hA5);
        chk("wr_known", $isunknown(ram_wdata[idx]), 0);
        wr++;
      end
      if (done[idx]) done_at = c;
      tick();
      start[idx] = 1'b0;
    end
    chk("n_writes", wr, len_i);
    chk("done_cycle", done_at, len_i + lat + 2);
  endtask

  logic [7:0]  t1_data [4] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};
  logic [12:0] t2_ad   [3] = '{13'h1FFE, 13'h1FFF, 13'h0000};
  logic [15:0] t2_addr [3] = '{16'hFFFF, 16'h0000, 16'h0001};
  logic [7:0]  t2_data [3] = '{8'h5B, 8'h5A, 8'hA5};

  initial begin
    int wcount;
    reset = 1'b1;
    start = '0;
    abort = '0;
    src   = '0;
    dst   = '0;
    len   = '0;
    repeat (3) tick();
    reset = 1'b0;

    for (int i = 0; i < NI; i++) begin
      chk("rst_ce", rom_ce[i], 0);
      chk("rst_oce", rom_oce[i], 0);
      chk("rst_ad", rom_ad[i], 0);
      chk("rst_we", ram_we[i], 0);
      chk("rst_addr", ram_addr[i], 0);
      chk("rst_wdata", ram_wdata[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_done", done[i], 0);
    end
    tick();

    // basic copy, len=4
    src = 13'h0000; dst = 16'h4000; len = 14'd4; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      chk("t1_busy", busy[0], (c <= 7));
      chk("t1_done", done[0], (c == 8));
      chk("t1_we", ram_we[0], (c >= 4 && c <= 7));
      if (c <= 6) chk("t1_ce_on", rom_ce[0] && rom_oce[0], 1);
      if (c >= 8) chk("t1_ce_off", rom_ce[0] || rom_oce[0], 0);
      if (c <= 4) chk("t1_ad", rom_ad[0], c - 1);
      if (c == 5 || c == 6) chk("t1_ad_hold", rom_ad[0], 3);
      if (c >= 4 && c <= 7) begin
        chk("t1_addr", ram_addr[0], 16'h4000 + c - 4);
        chk("t1_data", ram_wdata[0], t1_data[c-4]);
      end
      tick();
    end

    // address wrap on both sides
    src = 13'h1FFE; dst = 16'hFFFF; len = 14'd3; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("t2_we", ram_we[0], (c >= 4 && c <= 6));
      chk("t2_done", done[0], (c == 7));
      if (c <= 3) chk("t2_ad", rom_ad[0], t2_ad[c-1]);
      if (c >= 4 && c <= 6) begin
        chk("t2_addr", ram_addr[0], t2_addr[c-4]);
        chk("t2_data", ram_wdata[0], t2_data[c-4]);
      end
      tick();
    end

    // zero length
    src = 13'h0055; dst = 16'h1234; len = 14'd0; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("t3_done", done[0], (c == 1));
      chk("t3_busy", busy[0], 0);
      chk("t3_ce", rom_ce[0] || rom_oce[0], 0);
      chk("t3_we", ram_we[0], 0);
      tick();
    end

    // abort in cycle 10 of a 100-byte copy
    src = 13'h0000; dst = 16'h0100; len = 14'd100; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wcount = 0;
    for (int c = 1; c <= 11; c++) begin
      if (ram_we[0]) wcount++;
      if (c == 10) begin
        chk("t4_we_abort_cycle", ram_we[0], 1);
        abort[0] = 1'b1;
      end
      if (c == 11) begin
        chk("t4_ce", rom_ce[0], 0);
        chk("t4_oce", rom_oce[0], 0);
        chk("t4_we", ram_we[0], 0);
        chk("t4_busy", busy[0], 0);
      end
      chk("t4_no_done", done[0], 0);
      tick();
      abort[0] = 1'b0;
    end
    chk("t4_writes", wcount, 7);
    chk("t4_idle_done", done[0], 0);
    chk("t4_idle_busy", busy[0], 0);
    run_copy(0, 2, 32'h0010, 32'h0200, 2, 0, 1'b0);

    // start and abort together in IDLE: start wins
    tick();
    run_copy(0, 2, 32'h0040, 32'h3000, 2, 0, 1'b1);

    // second start mid-transfer is ignored
    tick();
    run_copy(0, 2, 32'h0080, 32'h5000, 8, 3, 1'b0);

    // synchronous reset in cycle 5
    tick();
    src = 13'h0000; dst = 16'h6000; len = 14'd20; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_ce", rom_ce[0], 0);
    chk("t5_oce", rom_oce[0], 0);
    chk("t5_ad", rom_ad[0], 0);
    chk("t5_we", ram_we[0], 0);
    chk("t5_addr", ram_addr[0], 0);
    chk("t5_wdata", ram_wdata[0], 0);
    chk("t5_busy", busy[0], 0);
    wcount = 0;
    for (int c = 0; c < 30; c++) begin
      if (done[0] || busy[0]) wcount++;
      tick();
    end
    chk("t5_quiet", wcount, 0);

    // full-size copies at the latency extremes
    run_copy(1, 1, 32'h0123, 32'h8000, 8192, 0, 1'b0);
    tick();
    run_copy(2, 4, 32'h1F00, 32'hF000, 8192, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
